// File: rtl/rtc_pkg.sv
// Purpose: shared constants for the RTC bus scheduler: register map, field limits, FSM states, edit modes.
// Latency: n/a (package only).
// Backpressure: n/a.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    // Edit modes carried on programacion
    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_DATE  = 2'b01;
    localparam logic [1:0] MODE_TIME  = 2'b10;
    localparam logic [1:0] MODE_TIMER = 2'b11;

    // Clock/calendar registers; the read burst walks 0x21..0x26 in this order
    localparam logic [7:0] ADDR_SEC      = 8'h21;
    localparam logic [7:0] ADDR_MIN      = 8'h22;
    localparam logic [7:0] ADDR_HOUR     = 8'h23;
    localparam logic [7:0] ADDR_DAY      = 8'h24;
    localparam logic [7:0] ADDR_MONTH    = 8'h25;
    localparam logic [7:0] ADDR_YEAR     = 8'h26;
    localparam logic [7:0] ADDR_TMR_SEC  = 8'h41;
    localparam logic [7:0] ADDR_TMR_MIN  = 8'h42;
    localparam logic [7:0] ADDR_TMR_HOUR = 8'h43;

    // Largest legal binary value per field
    localparam logic [5:0] MAX_HOUR  = 6'd23;
    localparam logic [5:0] MAX_MIN   = 6'd59;
    localparam logic [5:0] MAX_SEC   = 6'd59;
    localparam logic [5:0] MAX_DAY   = 6'd31;
    localparam logic [5:0] MAX_MONTH = 6'd12;
    localparam logic [5:0] MAX_YEAR  = 6'd63;

    // Clamp a field value to its maximum
    function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Purpose: 6-bit binary (0..63) to two-digit packed BCD {tens, ones}.
// Latency: combinational, zero cycles.
// Backpressure: none.
module bin2bcd6 (
    input  logic [5:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    // Divide by ten for the tens digit; remainder is the ones digit
    always_comb begin
        tens = 4'(bin / 6'd10);
        ones = 4'(bin - 6'(tens) * 6'd10);
        bcd  = {tens, ones};
    end

endmodule

// File: rtl/rtc_bus_sched.sv
// Purpose: arbitrates RTC field writes and six-register read bursts onto a single start/done bus.
// Latency: bus_start one cycle after a request is pending; rd_valid one cycle after bus_done.
// Backpressure: one write and one read request held pending; extra requests overwrite or drop.
module rtc_bus_sched
    import rtc_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int NREAD   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_read,
    input  logic       commit,
    input  logic [1:0] programacion,
    input  logic [1:0] seleccion,
    input  logic [5:0] cuenta,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic       bus_start,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       rd_valid,
    output logic [2:0] rd_index,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err
);

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_IDX = 3'(NREAD - 1);

    state_t     state;
    logic       wr_pend;
    logic       rd_pend;
    logic [1:0] lat_mode;
    logic [1:0] lat_sel;
    logic [5:0] lat_cnt;
    logic [2:0] idx;
    logic [7:0] wcnt;

    logic [7:0] wr_addr;
    logic [5:0] fmax;
    logic [5:0] sat_val;
    logic [7:0] wr_bcd;
    logic       commit_ok;
    logic       in_burst;

    assign commit_ok = commit && (programacion != MODE_NONE) && (seleccion != 2'd3);
    assign in_burst  = (state == RD_ISSUE) || (state == RD_WAIT);
    assign busy      = (state != IDLE);

    // Map the latched mode/field to its register address and field limit
    always_comb begin
        wr_addr = ADDR_TMR_SEC;
        fmax    = MAX_SEC;
        case (lat_mode)
            MODE_DATE: begin
                case (lat_sel)
                    2'd0:    begin wr_addr = ADDR_DAY;   fmax = MAX_DAY;   end
                    2'd1:    begin wr_addr = ADDR_MONTH; fmax = MAX_MONTH; end
                    default: begin wr_addr = ADDR_YEAR;  fmax = MAX_YEAR;  end
                endcase
            end
            MODE_TIME: begin
                case (lat_sel)
                    2'd0:    begin wr_addr = ADDR_HOUR; fmax = MAX_HOUR; end
                    2'd1:    begin wr_addr = ADDR_MIN;  fmax = MAX_MIN;  end
                    default: begin wr_addr = ADDR_SEC;  fmax = MAX_SEC;  end
                endcase
            end
            default: begin
                case (lat_sel)
                    2'd0:    begin wr_addr = ADDR_TMR_HOUR; fmax = MAX_HOUR; end
                    2'd1:    begin wr_addr = ADDR_TMR_MIN;  fmax = MAX_MIN;  end
                    default: begin wr_addr = ADDR_TMR_SEC;  fmax = MAX_SEC;  end
                endcase
            end
        endcase
    end

    assign sat_val = sat6(lat_cnt, fmax);

    bin2bcd6 u_bcd (
        .bin (sat_val),
        .bcd (wr_bcd)
    );

    // Scheduler FSM, pending-request capture and all registered bus/read outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            lat_mode  <= MODE_NONE;
            lat_sel   <= 2'd0;
            lat_cnt   <= 6'd0;
            idx       <= 3'd0;
            wcnt      <= 8'd0;
            err       <= 1'b0;
            bus_start <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 8'd0;
            bus_wdata <= 8'd0;
            rd_valid  <= 1'b0;
            rd_index  <= 3'd0;
            rd_data   <= 8'd0;
        end else begin
            bus_start <= 1'b0;
            rd_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_pend) begin
                        state     <= WR_ISSUE;
                        wr_pend   <= 1'b0;
                        bus_start <= 1'b1;
                        bus_wr    <= 1'b1;
                        bus_addr  <= wr_addr;
                        bus_wdata <= wr_bcd;
                    end else if (rd_pend) begin
                        state     <= RD_ISSUE;
                        rd_pend   <= 1'b0;
                        idx       <= 3'd0;
                        bus_start <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_addr  <= ADDR_SEC;
                    end
                end
                WR_ISSUE: begin
                    state <= WR_WAIT;
                    wcnt  <= 8'd0;
                end
                WR_WAIT: begin
                    if (bus_done) begin
                        state <= IDLE;
                    end else if (wcnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                    wcnt  <= 8'd0;
                end
                RD_WAIT: begin
                    if (bus_done) begin
                        rd_valid <= 1'b1;
                        rd_index <= idx;
                        rd_data  <= bus_rdata;
                        if (idx < LAST_IDX) begin
                            idx       <= idx + 3'd1;
                            state     <= RD_ISSUE;
                            bus_start <= 1'b1;
                            bus_wr    <= 1'b0;
                            bus_addr  <= ADDR_SEC + {5'd0, idx + 3'd1};
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wcnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // New requests are captured after the FSM so a same-cycle commit survives the clear
            if (commit_ok) begin
                wr_pend  <= 1'b1;
                lat_mode <= programacion;
                lat_sel  <= seleccion;
                lat_cnt  <= cuenta;
            end
            if (tick_read && !rd_pend && !in_burst) begin
                rd_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Purpose: scoreboard bench for rtc_bus_sched with a bus responder and a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_bus_sched;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_read;
    logic       commit;
    logic [1:0] programacion;
    logic [1:0] seleccion;
    logic [5:0] cuenta;
    logic       bus_done;
    logic [7:0] bus_rdata;
    logic       bus_start;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       rd_valid;
    logic [2:0] rd_index;
    logic [7:0] rd_data;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    txn_t       exp_bus[$];
    int         exp_idx[$];
    logic [7:0] data_q[$];

    logic resp_en    = 1'b1;
    int   resp_fixed = 0;
    logic resp_seq   = 1'b0;

    rtc_bus_sched #(.TIMEOUT(255), .NREAD(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_read    (tick_read),
        .commit       (commit),
        .programacion (programacion),
        .seleccion    (seleccion),
        .cuenta       (cuenta),
        .bus_done     (bus_done),
        .bus_rdata    (bus_rdata),
        .bus_start    (bus_start),
        .bus_wr       (bus_wr),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .rd_valid     (rd_valid),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .busy         (busy),
        .err          (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: which register a field edit targets and its clamped BCD value
    function automatic txn_t model_write(input logic [1:0] m, input logic [1:0] s, input logic [5:0] v);
        txn_t t;
        int   mx;
        int   val;
        int   a;
        if (m == 2'b01) begin
            a  = 'h24 + int'(s);
            mx = (s == 0) ? 31 : (s == 1) ? 12 : 63;
        end else begin
            a  = ((m == 2'b10) ? 'h23 : 'h43) - int'(s);
            mx = (s == 0) ? 23 : 59;
        end
        val     = (int'(v) > mx) ? mx : int'(v);
        t.wr    = 1'b1;
        t.addr  = 8'(a);
        t.wdata = 8'((val / 10) * 16 + (val % 10));
        return t;
    endfunction

    // Expected read-burst traffic: nstart register accesses, nvalid of them delivered
    task automatic push_burst(input int nstart, input int nvalid);
        txn_t t;
        for (int i = 0; i < nstart; i++) begin
            t.wr    = 1'b0;
            t.addr  = 8'('h21 + i);
            t.wdata = 8'd0;
            exp_bus.push_back(t);
        end
        for (int i = 0; i < nvalid; i++) exp_idx.push_back(i);
    endtask

    task automatic pulse(input logic c, input logic t, input logic [1:0] m,
                         input logic [1:0] s, input logic [5:0] v);
        @(posedge clk); #1;
        commit = c; tick_read = t; programacion = m; seleccion = s; cuenta = v;
        @(posedge clk); #1;
        commit = 1'b0; tick_read = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int quiet  = 0;
        int budget = 3000;
        repeat (2) @(negedge clk);
        while (quiet < 3 && budget > 0) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            budget--;
        end
        if (budget == 0) fail_now({nm, " idle wait expired"});
    endtask

    task automatic check_drained(input string nm);
        chk({nm, " bus queue left"}, exp_bus.size(), 0);
        chk({nm, " rd queue left"}, exp_idx.size(), 0);
    endtask

    // Bus responder: answers each access after a delay with read data
    initial begin
        logic       w;
        int         d;
        logic [7:0] rd8;
        bus_done  = 1'b0;
        bus_rdata = 8'd0;
        forever begin
            @(negedge clk);
            if (bus_start === 1'b1 && resp_en) begin
                w   = bus_wr;
                d   = (resp_fixed != 0) ? resp_fixed : int'($urandom_range(1, 6));
                rd8 = resp_seq ? 8'(8'h10 + (bus_addr - 8'h21)) : 8'($urandom_range(0, 255));
                repeat (d) @(posedge clk);
                #1;
                bus_done  = 1'b1;
                bus_rdata = rd8;
                if (!w) data_q.push_back(rd8);
                @(posedge clk); #1;
                bus_done  = 1'b0;
                bus_rdata = 8'd0;
            end
        end
    end

    // Monitor: every bus_start and rd_valid is matched against the expected queues
    always @(negedge clk) begin
        txn_t e;
        if (bus_start === 1'b1) begin
            if (exp_bus.size() == 0) begin
                fail_now("unexpected bus_start");
            end else begin
                e = exp_bus.pop_front();
                chk("bus_wr", bus_wr, e.wr);
                chk("bus_addr", bus_addr, e.addr);
                if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
            end
        end
        if (rd_valid === 1'b1) begin
            if (exp_idx.size() == 0) begin
                fail_now("unexpected rd_valid");
            end else begin
                chk("rd_index", rd_index, exp_idx.pop_front());
                if (data_q.size() == 0) fail_now("rd_valid without returned data");
                else chk("rd_data", rd_data, data_q.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t       t;
        logic [1:0] m;
        logic [1:0] s;
        logic [5:0] v;
        logic       c;
        logic       tk;
        logic       late_valid;
        txn_t       late_t;
        int         t0;
        int         budget;
        int         n;

        reset = 1'b0; tick_read = 1'b0; commit = 1'b0;
        programacion = 2'b00; seleccion = 2'd0; cuenta = 6'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst bus_start", bus_start, 0);
        chk("rst bus_wr", bus_wr, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_data", rd_data, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Time/minute write of 45
        resp_fixed = 3;
        t = model_write(2'b10, 2'd1, 6'd45);
        exp_bus.push_back(t);
        pulse(1'b1, 1'b0, 2'b10, 2'd1, 6'd45);
        wait_idle("write");
        check_drained("write");

        // Plain read burst with sequential data
        resp_seq = 1'b1;
        push_burst(6, 6);
        pulse(1'b0, 1'b1, 2'b00, 2'd0, 6'd0);
        wait_idle("burst");
        check_drained("burst");
        resp_seq = 1'b0;

        // Same-cycle commit and tick: month saturated to 12, then full burst
        exp_bus.push_back(model_write(2'b01, 2'd1, 6'd20));
        push_burst(6, 6);
        pulse(1'b1, 1'b1, 2'b01, 2'd1, 6'd20);
        wait_idle("prio");
        check_drained("prio");

        // Ignored commits
        pulse(1'b1, 1'b0, 2'b00, 2'd1, 6'd10);
        repeat (4) @(negedge clk);
        chk("invalid mode busy", busy, 0);
        pulse(1'b1, 1'b0, 2'b10, 2'd3, 6'd10);
        repeat (4) @(negedge clk);
        chk("invalid sel busy", busy, 0);

        // Timeout with no bus_done
        resp_en = 1'b0;
        push_burst(1, 0);
        pulse(1'b0, 1'b1, 2'b00, 2'd0, 6'd0);
        budget = 20;
        while (bus_start !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
        if (budget == 0) fail_now("timeout start wait expired");
        t0 = cyc;
        budget = 400;
        while (err !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
        if (budget == 0) fail_now("timeout err wait expired");
        chk("timeout cycles", 32'(cyc - t0), 256);
        chk("timeout busy", busy, 0);
        repeat (5) @(negedge clk);
        resp_en = 1'b1;
        push_burst(6, 6);
        pulse(1'b0, 1'b1, 2'b00, 2'd0, 6'd0);
        wait_idle("post-timeout");
        check_drained("post-timeout");
        chk("err sticky", err, 1);

        // Reset during the third read wait
        resp_fixed = 5;
        push_burst(3, 2);
        pulse(1'b0, 1'b1, 2'b00, 2'd0, 6'd0);
        n = 0;
        budget = 200;
        while (n < 3 && budget > 0) begin
            @(negedge clk);
            if (bus_start === 1'b1) n++;
            budget--;
        end
        if (budget == 0) fail_now("reset-test start wait expired");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst busy", busy, 0);
        chk("midrst err", err, 0);
        chk("midrst bus_start", bus_start, 0);
        chk("midrst bus_wr", bus_wr, 0);
        chk("midrst bus_addr", bus_addr, 0);
        chk("midrst rd_valid", rd_valid, 0);
        chk("midrst rd_index", rd_index, 0);
        chk("midrst rd_data", rd_data, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post-rst busy", busy, 0);
        check_drained("midrst");
        data_q.delete();
        resp_fixed = 0;

        // Randomized traffic, including commits and ticks while a burst runs
        for (int it = 0; it < 30; it++) begin
            c  = 1'($urandom_range(0, 1));
            tk = 1'($urandom_range(0, 1));
            m  = 2'($urandom_range(0, 3));
            s  = 2'($urandom_range(0, 3));
            v  = 6'($urandom_range(0, 63));
            if (c && m != 2'b00 && s != 2'd3) exp_bus.push_back(model_write(m, s, v));
            if (tk) push_burst(6, 6);
            pulse(c, tk, m, s, v);
            if (tk && $urandom_range(0, 1) == 1) pulse(1'b0, 1'b1, 2'b00, 2'd0, 6'd0);
            if (tk) begin
                budget = 300;
                @(negedge clk);
                while (rd_valid !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
                if (budget == 0) fail_now("random rd_valid wait expired");
                late_valid = 1'b0;
                n = int'($urandom_range(0, 2));
                for (int k = 0; k < n; k++) begin
                    m = 2'($urandom_range(0, 3));
                    s = 2'($urandom_range(0, 3));
                    v = 6'($urandom_range(0, 63));
                    if (m != 2'b00 && s != 2'd3) begin
                        late_valid = 1'b1;
                        late_t     = model_write(m, s, v);
                    end
                    pulse(1'b1, 1'($urandom_range(0, 1)), m, s, v);
                end
                if (late_valid) exp_bus.push_back(late_t);
            end
            wait_idle("random");
            check_drained("random");
        end

        chk("final data queue", data_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
